// File: rtl/aurora_tx_sched.sv
// aurora_tx_sched: packet-atomic scheduler for the single Aurora TX AXI-Stream port.
// Source 0 (loopback FIFO) is forwarded in loopback mode. Source 1 (sequence inserter)
// is released one packet per RX end-of-packet trigger, after a programmable delay.
// Optional statistics counters are built when AURORA_TX_SCHED_STATS_EN is defined.
module aurora_tx_sched #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_aresetn,
  input  logic               s0_axis_tvalid,
  input  logic [DATA_W-1:0]  s0_axis_tdata,
  input  logic               s0_axis_tlast,
  output logic               s0_axis_tready,
  input  logic               s1_axis_tvalid,
  input  logic [DATA_W-1:0]  s1_axis_tdata,
  input  logic               s1_axis_tlast,
  output logic               s1_axis_tready,
  output logic               m_axis_tvalid,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  input  logic               rx_tlast,
  input  logic               ctrl_loopback,
  input  logic [DELAY_W-1:0] ctrl_delay,
  input  logic               ctrl_clr,
  output logic               busy,
  output logic               sel,
  output logic               overrun
`ifdef AURORA_TX_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]   stat_pkt0,
  output logic [CNT_W-1:0]   stat_pkt1,
  output logic [CNT_W-1:0]   stat_drop
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, SEND0, SEND1} state_e;

  localparam logic [DELAY_W-1:0] ONE = DELAY_W'(1);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic               overrun_q, overrun_d;
  logic               dropEvent;
  logic               eop0;
  logic               eop1;

  // State, delay counter and sticky overrun flag registers.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state decode and zero-latency pass-through of the granted source.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dropEvent      = 1'b0;
    eop0           = 1'b0;
    eop1           = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_loopback) begin
          if (s0_axis_tvalid) state_d = SEND0;
        end else if (rx_tlast) begin
          if (ctrl_delay == '0) begin
            state_d = SEND1;
          end else begin
            state_d = WAIT;
            cnt_d   = ctrl_delay;
          end
        end
      end
      WAIT: begin
        dropEvent = rx_tlast;
        cnt_d     = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = SEND1;
      end
      SEND0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        s0_axis_tready = m_axis_tready;
        if (s0_axis_tvalid) begin
          m_axis_tdata = s0_axis_tdata;
          m_axis_tlast = s0_axis_tlast;
        end
        eop0 = s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
        if (eop0) state_d = IDLE;
      end
      SEND1: begin
        dropEvent      = rx_tlast;
        m_axis_tvalid  = s1_axis_tvalid;
        s1_axis_tready = m_axis_tready;
        if (s1_axis_tvalid) begin
          m_axis_tdata = s1_axis_tdata;
          m_axis_tlast = s1_axis_tlast;
        end
        eop1 = s1_axis_tvalid & m_axis_tready & s1_axis_tlast;
        if (eop1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun_d = dropEvent | (overrun_q & ~ctrl_clr);
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
  assign sel       = (state_q == WAIT) || (state_q == SEND1);

`ifdef AURORA_TX_SCHED_STATS_EN
  logic [CNT_W-1:0] pkt0_q;
  logic [CNT_W-1:0] pkt1_q;
  logic [CNT_W-1:0] drop_q;

  // Saturating event counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      pkt0_q <= '0;
      pkt1_q <= '0;
      drop_q <= '0;
    end else if (ctrl_clr) begin
      pkt0_q <= '0;
      pkt1_q <= '0;
      drop_q <= '0;
    end else begin
      if (eop0 && !(&pkt0_q)) pkt0_q <= pkt0_q + 1'b1;
      if (eop1 && !(&pkt1_q)) pkt1_q <= pkt1_q + 1'b1;
      if (dropEvent && !(&drop_q)) drop_q <= drop_q + 1'b1;
    end
  end

  assign stat_pkt0 = pkt0_q;
  assign stat_pkt1 = pkt1_q;
  assign stat_drop = drop_q;
`endif

endmodule

// File: tb/tb_aurora_tx_sched.sv
// Self-checking bench for aurora_tx_sched: a cycle table for the basic loopback and
// delayed-trigger flows, hand sequences for the multi-cycle corners, and randomized
// packets checked against a packet-level model of the scheduling rules.
module tb_aurora_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_axis_tvalid = 1'b0;
  logic [31:0] s0_axis_tdata = '0;
  logic        s0_axis_tlast = 1'b0;
  logic        s0_axis_tready;
  logic        s1_axis_tvalid = 1'b0;
  logic [31:0] s1_axis_tdata = '0;
  logic        s1_axis_tlast = 1'b0;
  logic        s1_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        rx_tlast = 1'b0;
  logic        ctrl_loopback = 1'b0;
  logic [15:0] ctrl_delay = '0;
  logic        ctrl_clr = 1'b0;
  logic        busy;
  logic        sel;
  logic        overrun;
`ifdef AURORA_TX_SCHED_STATS_EN
  logic [31:0] stat_pkt0;
  logic [31:0] stat_pkt1;
  logic [31:0] stat_drop;
`endif

  always #5 clk = ~clk;

  aurora_tx_sched #(.DATA_W(32), .DELAY_W(16), .CNT_W(32)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .rx_tlast       (rx_tlast),
    .ctrl_loopback  (ctrl_loopback),
    .ctrl_delay     (ctrl_delay),
    .ctrl_clr       (ctrl_clr),
    .busy           (busy),
    .sel            (sel),
    .overrun        (overrun)
`ifdef AURORA_TX_SCHED_STATS_EN
    ,
    .stat_pkt0      (stat_pkt0),
    .stat_pkt1      (stat_pkt1),
    .stat_drop      (stat_drop)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        loop;
    logic [15:0] delay;
    logic        rx;
    logic        s0v;
    logic [31:0] s0d;
    logic        s0l;
    logic        s1v;
    logic [31:0] s1d;
    logic        s1l;
    logic        mr;
    logic        expMv;
    logic [31:0] expMd;
    logic        expMl;
    logic        expS0r;
    logic        expS1r;
    logic        expBusy;
    logic        expSel;
    logic        expOv;
  } vec_t;

  vec_t  vecs[$];
  beat_t s0q[$];
  beat_t s1q[$];
  beat_t got[$];
  bit    s0Hold = 1'b0;
  bit    s1Hold = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    mPkt0 = 0;
  int    mPkt1 = 0;
  int    mDrop = 0;
  bit    ovModel = 1'b0;

  // Single comparison point: every check steps total, every failure steps bad.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compares the beats captured on the master side with an expected packet list.
  task automatic checkGot(input string name, input beat_t expq[$]);
    bit ok;
    ok = 1'b1;
    checkVal({name, "_len"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last) ok = 1'b0;
    checkVal({name, "_data"}, ok, 1);
  endtask

  task automatic addVec(input logic loop, input logic [15:0] delay, input logic rx,
                        input logic s0v, input logic [31:0] s0d, input logic s0l,
                        input logic s1v, input logic [31:0] s1d, input logic s1l, input logic mr,
                        input logic mv, input logic [31:0] md, input logic ml, input logic s0r,
                        input logic s1r, input logic bz, input logic sl, input logic ov);
    vec_t v;
    v.loop = loop; v.delay = delay; v.rx = rx;
    v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
    v.s1v = s1v; v.s1d = s1d; v.s1l = s1l; v.mr = mr;
    v.expMv = mv; v.expMd = md; v.expMl = ml; v.expS0r = s0r; v.expS1r = s1r;
    v.expBusy = bz; v.expSel = sl; v.expOv = ov;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    ctrl_loopback  = v.loop;
    ctrl_delay     = v.delay;
    rx_tlast       = v.rx;
    s0_axis_tvalid = v.s0v;
    s0_axis_tdata  = v.s0d;
    s0_axis_tlast  = v.s0l;
    s1_axis_tvalid = v.s1v;
    s1_axis_tdata  = v.s1d;
    s1_axis_tlast  = v.s1l;
    m_axis_tready  = v.mr;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    checkVal({t, "_mvalid"}, m_axis_tvalid, v.expMv);
    checkVal({t, "_mdata"}, m_axis_tdata, v.expMd);
    checkVal({t, "_mlast"}, m_axis_tlast, v.expMl);
    checkVal({t, "_s0ready"}, s0_axis_tready, v.expS0r);
    checkVal({t, "_s1ready"}, s1_axis_tready, v.expS1r);
    checkVal({t, "_busy"}, busy, v.expBusy);
    checkVal({t, "_sel"}, sel, v.expSel);
    checkVal({t, "_overrun"}, overrun, v.expOv);
  endtask

  // One clock cycle with AXI-compliant source models fed from s0q/s1q; returns #1 after
  // the falling edge so the caller can inspect the combinational outputs.
  task automatic doCycle(input bit mr, input bit rx, input bit clr, input bit gate);
    @(negedge clk);
    m_axis_tready = mr;
    rx_tlast      = rx;
    ctrl_clr      = clr;
    if (s0q.size() > 0 && (s0Hold || !gate || $urandom_range(9) < 7)) begin
      s0_axis_tvalid = 1'b1; s0_axis_tdata = s0q[0].data; s0_axis_tlast = s0q[0].last; s0Hold = 1'b1;
    end else begin
      s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    end
    if (s1q.size() > 0 && (s1Hold || !gate || $urandom_range(9) < 7)) begin
      s1_axis_tvalid = 1'b1; s1_axis_tdata = s1q[0].data; s1_axis_tlast = s1q[0].last; s1Hold = 1'b1;
    end else begin
      s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
    end
    #1;
    if (m_axis_tvalid && m_axis_tready) got.push_back('{data: m_axis_tdata, last: m_axis_tlast});
    if (s0_axis_tvalid && s0_axis_tready) begin
      if (s0_axis_tlast) mPkt0++;
      void'(s0q.pop_front());
      s0Hold = 1'b0;
    end
    if (s1_axis_tvalid && s1_axis_tready) begin
      if (s1_axis_tlast) mPkt1++;
      void'(s1q.pop_front());
      s1Hold = 1'b0;
    end
    if (clr) begin
      mPkt0 = 0; mPkt1 = 0; mDrop = 0;
    end
  endtask

  // One packet from the given source. Model: loopback grants the cycle after the source
  // shows valid in IDLE; a trigger grants source 1 exactly delay+1 cycles later; the
  // packet passes through unchanged; one IDLE cycle follows; extra triggers are dropped.
  task automatic runPacket(input int src, input int len, input int delay, input int extraK, input bit gate);
    beat_t pkt[$];
    int    grantCyc;
    bit    shapeOk;
    bit    done;
    bit    rx;
    bit    mr;
    bit    vld;
    bit    rdy;
    bit    ordy;
    shapeOk = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < len; i++) pkt.push_back('{data: $urandom, last: (i == len - 1)});
    foreach (pkt[i]) begin
      if (src == 0) s0q.push_back(pkt[i]);
      else s1q.push_back(pkt[i]);
    end
    got.delete();
    ctrl_loopback = (src == 0);
    ctrl_delay    = 16'(delay);
    grantCyc      = (src == 0) ? 1 : delay + 1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (src == 1) rx = (cyc == 0) || (extraK != 0 && cyc == extraK);
      else rx = (cyc > 0) && ($urandom_range(3) == 0);
      mr = gate ? ($urandom_range(9) < 7) : 1'b1;
      doCycle(mr, rx, 1'b0, gate && !(src == 0 && cyc == 0));
      if (src == 1 && extraK != 0 && cyc == extraK) begin
        mDrop++;
        ovModel = 1'b1;
      end
      vld  = (src == 0) ? s0_axis_tvalid : s1_axis_tvalid;
      rdy  = (src == 0) ? s0_axis_tready : s1_axis_tready;
      ordy = (src == 0) ? s1_axis_tready : s0_axis_tready;
      if (cyc == 0) shapeOk &= !busy;
      else if (cyc < grantCyc) shapeOk &= busy && sel && !m_axis_tvalid && !s0_axis_tready && !s1_axis_tready;
      else shapeOk &= busy && (sel == (src == 1)) && (m_axis_tvalid == vld) && (rdy == mr) && !ordy;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) done = 1'b1;
    end
    checkVal("pkt_done", done, 1);
    checkVal("pkt_shape", shapeOk, 1);
    checkGot("pkt_beats", pkt);
    doCycle(1'b1, 1'b0, 1'b0, gate);
    checkVal("pkt_idle_after", busy, 0);
    checkVal("pkt_overrun", overrun, ovModel);
    if (ovModel) begin
      doCycle(1'b1, 1'b0, 1'b1, gate);
      ovModel = 1'b0;
    end
  endtask

  // Watchdog so the run always ends even if the design locks up.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    beat_t expq[$];
    bit    stableOk;
    bit    prevStall;
    bit    done;
    bit    leakOk;
    logic [31:0] prevData;
    logic        prevLast;
    int    src;
    int    len;
    int    delay;
    int    extraK;

    // Reset state with busy-looking inputs applied.
    ctrl_loopback = 1'b1; s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'hAA; m_axis_tready = 1'b1;
    #12;
    checkVal("rst_mvalid", m_axis_tvalid, 0);
    checkVal("rst_mdata", m_axis_tdata, 0);
    checkVal("rst_s0ready", s0_axis_tready, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_overrun", overrun, 0);
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle table: loopback 3-beat packet, then delay-5 triggered 2-beat packet.
    addVec(1, 0, 0, 1, 32'h11, 0, 0, 0, 0, 1,  0, 32'h00, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 32'h11, 0, 0, 0, 0, 1,  1, 32'h11, 0, 1, 0, 1, 0, 0);
    addVec(1, 0, 1, 1, 32'h22, 0, 0, 0, 0, 1,  1, 32'h22, 0, 1, 0, 1, 0, 0);
    addVec(1, 0, 0, 1, 32'h33, 1, 0, 0, 0, 1,  1, 32'h33, 1, 1, 0, 1, 0, 0);
    addVec(1, 0, 1, 0, 32'h00, 0, 0, 0, 0, 1,  0, 32'h00, 0, 0, 0, 0, 0, 0);
    addVec(0, 5, 1, 0, 32'h00, 0, 1, 32'h05, 0, 1,  0, 32'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addVec(0, 2, 0, 0, 32'h00, 0, 1, 32'h05, 0, 1,  0, 32'h00, 0, 0, 0, 1, 1, 0);
    addVec(0, 2, 0, 0, 32'h00, 0, 1, 32'h05, 0, 1,  1, 32'h05, 0, 0, 1, 1, 1, 0);
    addVec(0, 2, 0, 0, 32'h00, 0, 1, 32'h03, 1, 1,  1, 32'h03, 1, 0, 1, 1, 1, 0);
    addVec(0, 0, 0, 0, 32'h00, 0, 0, 32'h00, 0, 1,  0, 32'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end
    mPkt0 = 1; mPkt1 = 1;

    // tready toggling during a triggered 2-beat packet: beats held while stalled.
    ctrl_loopback = 1'b0; ctrl_delay = 16'd0; got.delete();
    s1q.push_back('{data: 32'hA1, last: 1'b0});
    s1q.push_back('{data: 32'hB2, last: 1'b1});
    doCycle(1'b1, 1'b1, 1'b0, 1'b0);
    stableOk = 1'b1; prevStall = 1'b0; done = 1'b0; prevData = '0; prevLast = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      doCycle(i % 2 == 0, 1'b0, 1'b0, 1'b0);
      if (prevStall) stableOk &= m_axis_tvalid && (m_axis_tdata == prevData) && (m_axis_tlast == prevLast);
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevData  = m_axis_tdata;
      prevLast  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) done = 1'b1;
    end
    expq.delete();
    expq.push_back('{data: 32'hA1, last: 1'b0});
    expq.push_back('{data: 32'hB2, last: 1'b1});
    checkVal("toggle_done", done, 1);
    checkVal("toggle_stable", stableOk, 1);
    checkGot("toggle_beats", expq);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("toggle_idle", busy, 0);

    // Second trigger during WAIT is dropped: overrun set, only one packet leaves.
    ctrl_delay = 16'd4; got.delete();
    s1q.push_back('{data: 32'hE1, last: 1'b1});
    s1q.push_back('{data: 32'hE2, last: 1'b1});
    doCycle(1'b1, 1'b1, 1'b0, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 1'b1, 1'b0, 1'b0);
    mDrop++; ovModel = 1'b1;
    for (int i = 0; i < 12; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("ov_set", overrun, 1);
    checkVal("ov_one_pkt", got.size(), 1);
    checkVal("ov_pending", s1q.size(), 1);
`ifdef AURORA_TX_SCHED_STATS_EN
    checkVal("stat_drop_one", stat_drop, mDrop);
`endif
    doCycle(1'b1, 1'b0, 1'b1, 1'b0);
    ovModel = 1'b0;
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("ov_clr", overrun, 0);
`ifdef AURORA_TX_SCHED_STATS_EN
    checkVal("stat_drop_clr", stat_drop, 0);
`endif

    // Clear and a dropped trigger in the same cycle: the flag stays set.
    ctrl_delay = 16'd3;
    doCycle(1'b1, 1'b1, 1'b0, 1'b0);
    doCycle(1'b1, 1'b1, 1'b1, 1'b0);
    mDrop = 0; ovModel = 1'b1;
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("ov_set_wins", overrun, 1);
`ifdef AURORA_TX_SCHED_STATS_EN
    checkVal("stat_drop_clr_wins", stat_drop, 0);
`endif
    for (int i = 0; i < 10; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("ov_second_sent", s1q.size(), 0);
    doCycle(1'b1, 1'b0, 1'b1, 1'b0);
    ovModel = 1'b0;

    // Loopback flipped mid source-1 packet: source 1 finishes, then source 0 follows.
    ctrl_loopback = 1'b0; ctrl_delay = 16'd0; got.delete(); expq.delete();
    for (int i = 1; i <= 3; i++) begin
      s1q.push_back('{data: 32'hC0 + 32'(i), last: (i == 3)});
      expq.push_back('{data: 32'hC0 + 32'(i), last: (i == 3)});
    end
    doCycle(1'b1, 1'b1, 1'b0, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    ctrl_loopback = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      s0q.push_back('{data: 32'hD0 + 32'(i), last: (i == 2)});
      expq.push_back('{data: 32'hD0 + 32'(i), last: (i == 2)});
    end
    leakOk = 1'b1;
    for (int i = 0; i < 20 && got.size() < 5; i++) begin
      doCycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (sel && s0_axis_tready) leakOk = 1'b0;
      if (!sel && s1_axis_tready) leakOk = 1'b0;
    end
    checkVal("flip_no_leak", leakOk, 1);
    checkGot("flip_beats", expq);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("flip_idle", busy, 0);

    // Asynchronous reset in the middle of a loopback packet.
    got.delete();
    for (int i = 1; i <= 3; i++) s0q.push_back('{data: 32'hF0 + 32'(i), last: (i == 3)});
    doCycle(1'b0, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("midrst_pre_valid", m_axis_tvalid, 1);
    checkVal("midrst_pre_ready", s0_axis_tready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("midrst_mvalid", m_axis_tvalid, 0);
    checkVal("midrst_mdata", m_axis_tdata, 0);
    checkVal("midrst_mlast", m_axis_tlast, 0);
    checkVal("midrst_s0ready", s0_axis_tready, 0);
    checkVal("midrst_busy", busy, 0);
    @(negedge clk);
    s0q.delete(); s0Hold = 1'b0;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    rst_n = 1'b1;
    mPkt0 = 0; mPkt1 = 0; mDrop = 0; ovModel = 1'b0;
    runPacket(1, 2, 2, 0, 1'b0);

    // Randomized packets against the packet-level model.
    for (int it = 0; it < 40; it++) begin
      src    = int'($urandom_range(1));
      len    = int'($urandom_range(4, 1));
      delay  = int'($urandom_range(6));
      extraK = (src == 1 && $urandom_range(2) == 0) ? int'($urandom_range(delay + 1, 1)) : 0;
      runPacket(src, len, delay, extraK, 1'b1);
    end

`ifdef AURORA_TX_SCHED_STATS_EN
    checkVal("stat_pkt0", stat_pkt0, mPkt0);
    checkVal("stat_pkt1", stat_pkt1, mPkt1);
    checkVal("stat_drop", stat_drop, mDrop);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aurora_tx_sched.md
Name: aurora_tx_sched

Overview:
- Packet-atomic scheduler for the single Aurora 8b10b TX AXI-Stream slave port.
- Shares that port between two requesters: source 0 is the loopback FIFO output, source 1 is the sequence-number inserter (pre) output.
- In loopback mode, source 0 is forwarded whenever it has a packet.
- In normal mode, one source-1 packet is released per RX end-of-packet trigger, after a programmable delay. This replaces the fixed mux and the rtds_tx_pulse logic.

Parameters:
- DATA_W, 32, stream data width.
- DELAY_W, 16, width of the trigger-to-transmit delay counter.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- m_axis_aclk  in  1  user_clk_out domain clock.
- m_axis_aresetn  in  1  asynchronous active-low reset.
- s0_axis_tvalid/tdata/tlast  in  1/DATA_W/1  source 0 (loopback FIFO).
- s0_axis_tready  out  1
- s1_axis_tvalid/tdata/tlast  in  1/DATA_W/1  source 1 (pre).
- s1_axis_tready  out  1
- m_axis_tvalid/tdata/tlast  out  1/DATA_W/1  to Aurora s_axi_tx_*.
- m_axis_tready  in  1  Aurora s_axi_tx_tready.
- rx_tlast  in  1  Aurora m_axi_rx_tlast; each cycle it is high counts as one trigger.
- ctrl_loopback  in  1  1 = forward source 0; 0 = triggered source 1.
- ctrl_delay  in  DELAY_W  cycles between trigger and grant.
- ctrl_clr  in  1  synchronous clear of the sticky flag and counters.
- busy  out  1  state is not IDLE.
- sel  out  1  currently granted source.
- overrun  out  1  sticky; set when a trigger arrives while in WAIT or SEND1.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, sel = 0, busy = 0, overrun = 0, delay counter = 0.
  - All tready outputs = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
- States: IDLE, WAIT, SEND0, SEND1.
- ctrl_loopback and ctrl_delay are sampled only in IDLE. A change during WAIT or SEND takes effect at the next IDLE.
- IDLE transitions:
  - ctrl_loopback = 1 and s0_axis_tvalid = 1 → SEND0 next cycle.
  - ctrl_loopback = 0 and rx_tlast = 1 and ctrl_delay = 0 → SEND1 next cycle.
  - ctrl_loopback = 0 and rx_tlast = 1 and ctrl_delay ≠ 0 → WAIT; counter loaded with ctrl_delay.
  - In loopback mode, triggers are ignored and do not set overrun.
- WAIT:
  - Counter decrements each cycle.
  - When counter = 1 → SEND1.
  - The first SEND1 cycle is therefore exactly ctrl_delay + 1 cycles after the trigger cycle.
- SEND0 / SEND1:
  - Zero-latency combinational pass-through: m_axis_* = granted s*_axis_*, and granted tready = m_axis_tready.
  - Ungranted tready = 0. In IDLE and WAIT, both treadys = 0 and m_axis_tvalid = 0.
  - m_axis_tdata and m_axis_tlast are driven 0 whenever m_axis_tvalid = 0.
  - A stalled source (tvalid low) keeps the grant; no timeout.
- End of packet: on the beat where tvalid & tready & tlast, state → IDLE next cycle.
  - Minimum one IDLE cycle between packets.
  - A single-beat packet holds the grant for one beat.
- Trigger during WAIT or SEND1: the trigger is dropped and overrun is set. It is not queued.
- Triggers during SEND0 are ignored.
- Simultaneous events:
  - ctrl_clr and an overrun event in the same cycle → overrun = 1 (set wins).
  - rx_tlast in IDLE with loopback = 0 starts WAIT/SEND1 regardless of s1_axis_tvalid. SEND1 then waits for source 1 to present its packet.
- sel = 1 in WAIT and SEND1, 0 otherwise. busy = (state ≠ IDLE).
- Reset asserted mid-packet: the grant is lost immediately and the partial packet is abandoned. Upstream FIFOs are reset by the same signal.

Optional Feature:
- Macro: AURORA_TX_SCHED_STATS_EN.
- Defined:
  - Extra outputs stat_pkt0, stat_pkt1, stat_drop, each CNT_W bits.
  - stat_pkt0 / stat_pkt1 increment on each completed packet of source 0 / source 1 (the tlast handshake).
  - stat_drop increments on each dropped trigger.
  - Counters saturate at all-ones, reset to 0, and are cleared by ctrl_clr. An increment in the same cycle as ctrl_clr leaves the counter at 0.
- Not defined: the ports are absent and no counter logic is built; all other behaviour is identical.

Test Plan:
- Loopback = 1, source 0 sends 3-beat packet 0x11, 0x22, 0x33 with m_axis_tready = 1 → the same beats appear on m_axis, tlast on 0x33, s1_axis_tready = 0 throughout, busy falls 1 cycle after the last beat.
- Loopback = 0, ctrl_delay = 5, rx_tlast pulse at cycle T, source 1 holds {0x05, 0x03} → first m_axis_tvalid beat at cycle T+6, then return to IDLE and overrun = 0.
- Loopback = 0, ctrl_delay = 0, trigger, m_axis_tready toggling 1,0,1,0 → each beat is held stable while tready = 0, 2 beats delivered and none lost or duplicated.
- Second rx_tlast during WAIT → overrun = 1 and only 1 packet sent; ctrl_clr → overrun = 0 (with STATS_EN: stat_drop = 1, then 0 after ctrl_clr).
- ctrl_loopback flipped 0→1 in the middle of a SEND1 packet → the packet completes on source 1, the next packet comes from source 0, no beat is interleaved.
- m_axis_aresetn pulled low in the middle of a packet → all outputs go to 0 asynchronously; after release, state is IDLE and the next trigger behaves normally.
